// File: rtl/dram_lsu_mem_if.sv
// dram_lsu_mem_if: request/response bundle between the load/store unit and
// the data memory.
//   req_valid/req_ready : request handshake (accept on valid & ready at posedge)
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32I load/store width/extension code
//   req_addr/req_wdata  : byte address and right-justified store data
//   flush               : squash every response still in flight
//   rsp_valid           : one-cycle pulse per accepted, unsquashed request
//   rsp_rdata           : extended load data (0 for stores and faults)
//   rsp_err             : 00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3
//   rsp_is_store        : echoes req_we of the responding request
interface dram_lsu_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        rsp_is_store;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, flush,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_store
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, flush,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_store
  );
endinterface

// File: rtl/dram_lsu_mem.sv
// dram_lsu_mem: byte-addressable data memory for the pipelined RV32I core.
// Four 8-bit lane banks, valid/ready request port, RD_LATENCY-deep response
// pipeline, internal load extension, byte-lane stores and fault reporting.
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : synchronous active-low reset (memory contents are kept)
//   bus   : dram_lsu_mem_if.slave request/response bundle
module dram_lsu_mem #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  dram_lsu_mem_if.slave  bus
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int IW    = ADDR_WIDTH - 2;

  // Shift the addressed bytes down to bit 0, then sign/zero extend.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'h00_0000, sh[7:0]};
      3'b101:  load_ext = {16'h0000, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  logic [7:0]            bank_q [4][DEPTH];
  logic                  ready_q;
  logic [RD_LATENCY-1:0] vld_q;
  logic [31:0]           data_q [RD_LATENCY];
  logic [1:0]            err_q  [RD_LATENCY];
  logic [RD_LATENCY-1:0] st_q;

  logic [31:0] off_d;
  logic [IW-1:0] idx_d;
  logic        oor_d;
  logic        ill_d;
  logic        mis_d;
  logic [1:0]  err_d;
  logic        acc_d;
  logic        wr_d;
  logic [3:0]  strb_d;
  logic [31:0] wlane_d;
  logic [31:0] rword_d;
  logic        vld0_d;
  logic [31:0] data0_d;
  logic [1:0]  err0_d;
  logic        st0_d;

  // Address decode: offset from BASE_ADDR; anything above the window is out of range.
  assign off_d   = bus.req_addr - BASE_ADDR;
  assign idx_d   = off_d[ADDR_WIDTH-1:2];
  assign oor_d   = |off_d[31:ADDR_WIDTH];
  assign rword_d = {bank_q[3][idx_d], bank_q[2][idx_d], bank_q[1][idx_d], bank_q[0][idx_d]};
  // Gating with rst_n keeps the reset edge from accepting a request.
  assign acc_d   = bus.req_valid & ready_q & rst_n;

  // Fault classification; illegal funct3 outranks misalignment, which outranks range.
  always_comb begin
    ill_d = 1'b0;
    mis_d = 1'b0;
    err_d = 2'b00;
    case (bus.req_funct3)
      3'b000:          ill_d = 1'b0;
      3'b001:          ill_d = 1'b0;
      3'b010:          ill_d = 1'b0;
      3'b100, 3'b101:  ill_d = bus.req_we;
      default:         ill_d = 1'b1;
    endcase
    case (bus.req_funct3[1:0])
      2'b01:   mis_d = bus.req_addr[0];
      2'b10:   mis_d = |bus.req_addr[1:0];
      default: mis_d = 1'b0;
    endcase
    if (ill_d) begin
      err_d = 2'b11;
    end else if (mis_d) begin
      err_d = 2'b01;
    end else if (oor_d) begin
      err_d = 2'b10;
    end else begin
      err_d = 2'b00;
    end
  end

  // Store lane strobes and data replicated across lanes.
  always_comb begin
    strb_d  = 4'b0000;
    wlane_d = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        strb_d  = 4'b0001 << off_d[1:0];
        wlane_d = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        strb_d  = off_d[1] ? 4'b1100 : 4'b0011;
        wlane_d = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        strb_d  = 4'b1111;
        wlane_d = bus.req_wdata;
      end
    endcase
  end

  assign wr_d = acc_d & bus.req_we & (err_d == 2'b00);

  // First response stage contents; non-accepting cycles load zeros.
  always_comb begin
    vld0_d  = 1'b0;
    data0_d = 32'h0000_0000;
    err0_d  = 2'b00;
    st0_d   = 1'b0;
    if (acc_d) begin
      vld0_d = ~bus.flush;
      err0_d = err_d;
      st0_d  = bus.req_we;
      if (!bus.req_we && (err_d == 2'b00)) begin
        data0_d = load_ext(rword_d, off_d[1:0], bus.req_funct3);
      end else begin
        data0_d = 32'h0000_0000;
      end
    end else begin
      vld0_d = 1'b0;
    end
  end

  // Lane banks: byte-strobed write at the accept edge, never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_d && strb_d[i]) begin
        bank_q[i][idx_d] <= wlane_d[8*i +: 8];
      end
    end
  end

  // Ready flag and response pipeline; flush clears every valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      vld_q   <= '0;
      st_q    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        data_q[i] <= 32'h0000_0000;
        err_q[i]  <= 2'b00;
      end
    end else begin
      ready_q   <= 1'b1;
      vld_q[0]  <= vld0_d;
      data_q[0] <= data0_d;
      err_q[0]  <= err0_d;
      st_q[0]   <= st0_d;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1] & ~bus.flush;
        data_q[i] <= data_q[i-1];
        err_q[i]  <= err_q[i-1];
        st_q[i]   <= st_q[i-1];
      end
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.rsp_valid    = vld_q[RD_LATENCY-1];
  assign bus.rsp_rdata    = data_q[RD_LATENCY-1];
  assign bus.rsp_err      = err_q[RD_LATENCY-1];
  assign bus.rsp_is_store = st_q[RD_LATENCY-1];

endmodule

// File: tb/tb_dram_lsu_mem.sv
// tb_dram_lsu_mem: drives three memories (RD_LATENCY 1, 2, 3) with identical
// stimulus and checks each against a byte-array model with per-latency queues
// of expected responses keyed by the edge at which they must be visible.
module tb_dram_lsu_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_we    = 1'b0;
  logic [2:0]  s_f3    = 3'b000;
  logic [31:0] s_addr  = 32'h0;
  logic [31:0] s_wdata = 32'h0;
  logic        s_flush = 1'b0;

  dram_lsu_mem_if if1 ();
  dram_lsu_mem_if if2 ();
  dram_lsu_mem_if if3 ();

  assign if1.req_valid = s_valid; assign if1.req_we = s_we; assign if1.req_funct3 = s_f3;
  assign if1.req_addr = s_addr;   assign if1.req_wdata = s_wdata; assign if1.flush = s_flush;
  assign if2.req_valid = s_valid; assign if2.req_we = s_we; assign if2.req_funct3 = s_f3;
  assign if2.req_addr = s_addr;   assign if2.req_wdata = s_wdata; assign if2.flush = s_flush;
  assign if3.req_valid = s_valid; assign if3.req_we = s_we; assign if3.req_funct3 = s_f3;
  assign if3.req_addr = s_addr;   assign if3.req_wdata = s_wdata; assign if3.flush = s_flush;

  dram_lsu_mem #(.RD_LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  dram_lsu_mem #(.RD_LATENCY(2)) u_l2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  dram_lsu_mem #(.RD_LATENCY(3)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [1:0]  e;
    logic        s;
  } rsp_t;

  int     vectors = 0;
  int     miscompares = 0;
  int     edge_n = 0;
  logic   ready_m = 1'b0;
  logic [7:0] mem_m [1024];
  rsp_t   exp_q [3][$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, edge_n, act, req);
    end
  endfunction

  // Model of one posedge: reset, fault rules, byte memory, load extension, flush.
  function automatic void model_edge();
    int          size;
    logic        legal;
    logic [1:0]  err;
    logic [31:0] val;
    rsp_t        it;
    if (!rst_n) begin
      for (int l = 0; l < 3; l++) exp_q[l].delete();
      ready_m = 1'b0;
      return;
    end
    if (s_flush) begin
      for (int l = 0; l < 3; l++)
        while (exp_q[l].size() > 0 && exp_q[l][$].due >= edge_n) void'(exp_q[l].pop_back());
    end
    if (s_valid && ready_m) begin
      size  = (s_f3[1:0] == 2'd0) ? 1 : (s_f3[1:0] == 2'd1) ? 2 : 4;
      legal = (s_f3 == 3'd0) || (s_f3 == 3'd1) || (s_f3 == 3'd2) ||
              (((s_f3 == 3'd4) || (s_f3 == 3'd5)) && !s_we);
      val = 32'h0;
      if (!legal) err = 2'b11;
      else if ((s_addr & (size - 1)) != 0) err = 2'b01;
      else if (s_addr >= 32'd1024) err = 2'b10;
      else err = 2'b00;
      if (err == 2'b00) begin
        if (s_we) begin
          for (int b = 0; b < size; b++) mem_m[s_addr[9:0] + b] = s_wdata[8*b +: 8];
        end else begin
          for (int b = 0; b < size; b++) val = val | (32'(mem_m[s_addr[9:0] + b]) << (8*b));
          if (!s_f3[2] && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
          if (!s_f3[2] && size == 2 && val[15]) val = val | 32'hFFFF_0000;
        end
      end
      if (!s_flush) begin
        for (int l = 0; l < 3; l++) begin
          it.due = edge_n + l; it.d = val; it.e = err; it.s = s_we;
          exp_q[l].push_back(it);
        end
      end
    end
    ready_m = 1'b1;
  endfunction

  function automatic void check_lat(input int li, input logic v, input logic [31:0] d,
                                    input logic [1:0] e, input logic s, input logic rdy);
    rsp_t it;
    chk($sformatf("L%0d_ready", li + 1), 32'(rdy), 32'(ready_m));
    if (!rst_n) begin
      chk($sformatf("L%0d_rst_valid", li + 1), 32'(v), 32'h0);
      chk($sformatf("L%0d_rst_rdata", li + 1), d, 32'h0);
      chk($sformatf("L%0d_rst_err", li + 1), 32'(e), 32'h0);
      chk($sformatf("L%0d_rst_store", li + 1), 32'(s), 32'h0);
    end else if (exp_q[li].size() > 0 && exp_q[li][0].due == edge_n) begin
      it = exp_q[li].pop_front();
      chk($sformatf("L%0d_valid", li + 1), 32'(v), 32'h1);
      chk($sformatf("L%0d_rdata", li + 1), d, it.d);
      chk($sformatf("L%0d_err", li + 1), 32'(e), 32'(it.e));
      chk($sformatf("L%0d_store", li + 1), 32'(s), 32'(it.s));
    end else begin
      chk($sformatf("L%0d_idle_valid", li + 1), 32'(v), 32'h0);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check_lat(0, if1.rsp_valid, if1.rsp_rdata, if1.rsp_err, if1.rsp_is_store, if1.req_ready);
    check_lat(1, if2.rsp_valid, if2.rsp_rdata, if2.rsp_err, if2.rsp_is_store, if2.req_ready);
    check_lat(2, if3.rsp_valid, if3.rsp_rdata, if3.rsp_err, if3.rsp_is_store, if3.req_ready);
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic fl);
    s_valid = 1'b1; s_we = we; s_f3 = f3; s_addr = a; s_wdata = wd; s_flush = fl;
  endtask

  task automatic idle();
    s_valid = 1'b0; s_flush = 1'b0;
  endtask

  // One request on the latency-1 memory with hand-computed expected response.
  task automatic lit(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] ed, input logic [1:0] ee);
    drive(we, f3, a, wd, 1'b0);
    step();
    chk({nm, "_v"}, 32'(if1.rsp_valid), 32'h1);
    chk({nm, "_d"}, if1.rsp_rdata, ed);
    chk({nm, "_e"}, 32'(if1.rsp_err), 32'(ee));
    idle();
  endtask

  logic [2:0] f3_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("ready_after_release", 32'(if1.req_ready), 32'h1);

    // Give every word a known value.
    for (int w = 0; w < 256; w++) begin
      drive(1'b1, 3'd2, 32'(w * 4), 32'h0, 1'b0);
      step();
    end
    idle(); step();

    lit("sw_10",    1'b1, 3'd2, 32'h10,  32'h8765_4321, 32'h0, 2'b00);
    lit("lw_10",    1'b0, 3'd2, 32'h10,  32'h0, 32'h8765_4321, 2'b00);
    lit("sb_13",    1'b1, 3'd0, 32'h13,  32'h0000_00AA, 32'h0, 2'b00);
    lit("lb_13",    1'b0, 3'd0, 32'h13,  32'h0, 32'hFFFF_FFAA, 2'b00);
    lit("lbu_13",   1'b0, 3'd4, 32'h13,  32'h0, 32'h0000_00AA, 2'b00);
    lit("lh_12",    1'b0, 3'd1, 32'h12,  32'h0, 32'hFFFF_AA65, 2'b00);
    lit("lhu_10",   1'b0, 3'd5, 32'h10,  32'h0, 32'h0000_4321, 2'b00);
    lit("lw_12_mis",1'b0, 3'd2, 32'h12,  32'h0, 32'h0, 2'b01);
    lit("sh_11_mis",1'b1, 3'd1, 32'h11,  32'hFFFF, 32'h0, 2'b01);
    lit("lw_10_b",  1'b0, 3'd2, 32'h10,  32'h0, 32'hAA65_4321, 2'b00);
    lit("f3_011",   1'b0, 3'd3, 32'h10,  32'h0, 32'h0, 2'b11);
    lit("sbu_ill",  1'b1, 3'd4, 32'h10,  32'h0, 32'h0, 2'b11);
    lit("lw_400",   1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 2'b10);
    lit("sw_400",   1'b1, 3'd2, 32'h400, 32'h1234_5678, 32'h0, 2'b10);
    lit("lw_000",   1'b0, 3'd2, 32'h000, 32'h0, 32'h0, 2'b00);
    lit("lw_402",   1'b0, 3'd2, 32'h402, 32'h0, 32'h0, 2'b01);
    lit("f3_111",   1'b0, 3'd7, 32'h401, 32'h0, 32'h0, 2'b11);

    // Back-to-back loads on the latency-3 memory.
    lit("sw_0", 1'b1, 3'd2, 32'h0, 32'h1111_1111, 32'h0, 2'b00);
    lit("sw_4", 1'b1, 3'd2, 32'h4, 32'h2222_2222, 32'h0, 2'b00);
    lit("sw_8", 1'b1, 3'd2, 32'h8, 32'h3333_3333, 32'h0, 2'b00);
    step(); step();
    drive(1'b0, 3'd2, 32'h0, 32'h0, 1'b0); step();
    chk("l3_b2b_0_v", 32'(if3.rsp_valid), 32'h0);
    drive(1'b0, 3'd2, 32'h4, 32'h0, 1'b0); step();
    chk("l3_b2b_1_v", 32'(if3.rsp_valid), 32'h0);
    drive(1'b0, 3'd2, 32'h8, 32'h0, 1'b0); step();
    chk("l3_b2b_2_v", 32'(if3.rsp_valid), 32'h1);
    chk("l3_b2b_2_d", if3.rsp_rdata, 32'h1111_1111);
    idle(); step();
    chk("l3_b2b_3_d", if3.rsp_rdata, 32'h2222_2222);
    step();
    chk("l3_b2b_4_d", if3.rsp_rdata, 32'h3333_3333);
    step();
    chk("l3_b2b_5_v", 32'(if3.rsp_valid), 32'h0);

    // Flush two in-flight loads on the latency-2 memory.
    drive(1'b0, 3'd2, 32'h0, 32'h0, 1'b0); step();
    drive(1'b0, 3'd2, 32'h4, 32'h0, 1'b1); step();
    chk("l2_flush_a", 32'(if2.rsp_valid), 32'h0);
    drive(1'b0, 3'd2, 32'h8, 32'h0, 1'b0); step();
    chk("l2_flush_b", 32'(if2.rsp_valid), 32'h0);
    idle(); step();
    chk("l2_after_flush_v", 32'(if2.rsp_valid), 32'h1);
    chk("l2_after_flush_d", if2.rsp_rdata, 32'h3333_3333);
    step(); step();

    // A store accepted under flush is still written.
    drive(1'b1, 3'd2, 32'h20, 32'h5A5A_5A5A, 1'b1); step();
    chk("flush_store_nov", 32'(if1.rsp_valid), 32'h0);
    lit("lw_20", 1'b0, 3'd2, 32'h20, 32'h0, 32'h5A5A_5A5A, 2'b00);

    // Reset in the middle of traffic.
    drive(1'b0, 3'd2, 32'h0, 32'h0, 1'b0); step();
    rst_n = 1'b0; drive(1'b0, 3'd2, 32'h4, 32'h0, 1'b0); step();
    chk("rst_ready", 32'(if1.req_ready), 32'h0);
    chk("rst_l3_v", 32'(if3.rsp_valid), 32'h0);
    rst_n = 1'b1; idle(); step();
    chk("rel_ready", 32'(if3.req_ready), 32'h1);
    step(); step();
    lit("lw_10_kept", 1'b0, 3'd2, 32'h10, 32'h0, 32'hAA65_4321, 2'b00);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      s_valid = ($urandom_range(0, 9) < 8);
      s_we    = ($urandom_range(0, 9) < 4);
      s_f3    = f3_tab[$urandom_range(0, 9)];
      r = $urandom_range(0, 19);
      if (r == 0)      s_addr = $urandom;
      else if (r == 1) s_addr = 32'h400 + 32'($urandom_range(0, 1023));
      else             s_addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (s_f3[1:0] == 2'd1) s_addr[0] = 1'b0;
        if (s_f3[1:0] == 2'd2) s_addr[1:0] = 2'b00;
      end
      s_wdata = $urandom;
      s_flush = ($urandom_range(0, 29) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1; idle();
    step(); step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
